// File: rtl/serial_rx.sv
// -----------------------------------------------------------------------------
// serial_rx -- 8N1 UART receiver, LSB first, idle-high line.
//
// The bit period is DIV = CLK_HZ / BAUD clocks (DIV >= 4).
// Bits are sampled at mid-bit, timed from the first low synchronized sample (t0):
//   - start bit at t0 + DIV/2
//   - data bit k at t0 + DIV/2 + (k+1)*DIV
//   - stop bit at t0 + DIV/2 + 9*DIV
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rxd        asynchronous serial input (idle high)
//   dout[7:0]  last good byte, held until the next good frame
//   valid      one-cycle pulse when dout updates
//   ferr       one-cycle pulse when a stop bit is sampled low
//   busy       high in any state other than IDLE
//   hex_hi     dout[7:4]
//   hex_lo     dout[3:0]
//   dbg_state  current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Output handshake: valid and ferr are single-cycle strobes. There is no ready
// input; a consumer must capture dout in the cycle valid is high. dout holds
// its value until the next good frame, so a late read still sees the same byte.
// -----------------------------------------------------------------------------
module serial_rx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] dout,
  output logic       valid,
  output logic       ferr,
  output logic       busy,
  output logic [3:0] hex_hi,
  output logic [3:0] hex_lo,
  output logic [1:0] dbg_state
);

  localparam int DIV = CLK_HZ / BAUD;
  // Wide enough to hold DIV-1. For DIV = 2**16 this is 16 bits.
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

  // Counter reload values.
  // The counter counts down to zero, so a reload of N-1 gives a sample N
  // cycles after the reload.
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_rxd_s;
  logic            r_rxd_prev;
  logic [CW-1:0]   r_baud;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic            w_fall;
  logic            w_tick;

  // Two-flop synchronizer, plus one more flop for falling-edge detection.
  // All three flops reset to 1 so that a reset reads as an idle line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b1;
      r_rxd_s    <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_sync1    <= rxd;
      r_rxd_s    <= r_sync1;
      r_rxd_prev <= r_rxd_s;
    end
  end

  assign w_fall = r_rxd_prev & ~r_rxd_s;
  assign w_tick = (r_baud == '0);

  // Receive FSM.
  // Falling edges are only looked at in IDLE, so a frame is never
  // resynchronized once it has started.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      dout     <= '0;
      valid    <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      valid <= 1'b0;
      ferr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_bitcnt <= '0;
            r_baud   <= HALF_M1;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (!r_rxd_s) begin
              r_baud  <= FULL_M1;
              r_state <= S_DATA;
            end else begin
              // The line was high again at mid start bit, so treat it as a glitch.
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift  <= {r_rxd_s, r_shift[7:1]};
            r_baud   <= FULL_M1;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_rxd_s) begin
              dout  <= r_shift;
              valid <= 1'b1;
            end else begin
              ferr <= 1'b1;
            end
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign hex_hi    = dout[7:4];
  assign hex_lo    = dout[3:0];
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_rx -- directed self-checking bench for serial_rx.
// CLK_HZ = 16, BAUD = 1, so DIV = 16.
// Inputs are driven on falling clock edges, and outputs are sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_serial_rx;

  localparam int DIV = 16;
  localparam int CLK_PERIOD = 10;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] dout;
  logic       valid;
  logic       ferr;
  logic       busy;
  logic [3:0] hex_hi;
  logic [3:0] hex_lo;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  logic prev_valid = 1'b0;
  logic prev_ferr  = 1'b0;
  time  t_start = 0;
  time  t_valid = 0;

  logic [7:0] exp_q[$];

  serial_rx #(.CLK_HZ(16), .BAUD(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .dout      (dout),
    .valid     (valid),
    .ferr      (ferr),
    .busy      (busy),
    .hex_hi    (hex_hi),
    .hex_lo    (hex_lo),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #(CLK_PERIOD / 2) clk = ~clk;

  initial begin
    #(200000);
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // The task is called right after a falling edge.
  // It drives the start bit, the 8 data bits (LSB first) and the stop bit,
  // holding each one for DIV cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    t_start = $time;
    wait_n(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_n(DIV);
    end
    rxd = stop_bit;
    wait_n(DIV);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      t_valid = $time;
      check_eq("valid_ferr_excl", 32'(ferr), 32'd0);
      check_eq("valid_width", 32'(prev_valid), 32'd0);
      if (exp_q.size() > 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check_eq("dout", 32'(dout), 32'(e));
        check_eq("hex_hi", 32'(hex_hi), 32'(e[7:4]));
        check_eq("hex_lo", 32'(hex_lo), 32'(e[3:0]));
      end else begin
        check_eq("unexpected_valid", 32'(valid), 32'd0);
      end
    end
    if (ferr) begin
      n_ferr++;
      check_eq("ferr_width", 32'(prev_ferr), 32'd0);
    end
    prev_valid = valid;
    prev_ferr  = ferr;
  end

  // ---------------- stimulus ----------------
  int v0;
  int f0;

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    wait_n(4);
    // Check the outputs while reset is held.
    check_eq("rst_dout", 32'(dout), 32'h00);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_ferr", 32'(ferr), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_hex", 32'({hex_hi, hex_lo}), 32'h00);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    wait_n(5);

    // Single frame 0xA5.
    v0 = n_valid; f0 = n_ferr;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_n(20);
    check_eq("a5_nvalid", 32'(n_valid - v0), 32'd1);
    check_eq("a5_nferr", 32'(n_ferr - f0), 32'd0);
    check_eq("a5_busy", 32'(busy), 32'd0);
    check_eq("a5_dout", 32'(dout), 32'hA5);
    check_eq("a5_hex_hi", 32'(hex_hi), 32'hA);
    check_eq("a5_hex_lo", 32'(hex_lo), 32'h5);

    // Two frames sent back to back: 0x3C, then 0xF0.
    v0 = n_valid;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hF0);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hF0, 1'b1);
    wait_n(20);
    check_eq("b2b_nvalid", 32'(n_valid - v0), 32'd2);
    check_eq("b2b_dout", 32'(dout), 32'hF0);

    // Framing error on 0x81, followed by a line held low (break).
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h81, 1'b0);
    wait_n(20);
    check_eq("brk_busy_a", 32'(busy), 32'd0);
    wait_n(20);
    check_eq("brk_busy_b", 32'(busy), 32'd0);
    check_eq("brk_state", 32'(dbg_state), 32'd0);
    rxd = 1'b1;
    wait_n(30);
    check_eq("ferr_nferr", 32'(n_ferr - f0), 32'd1);
    check_eq("ferr_nvalid", 32'(n_valid - v0), 32'd0);
    check_eq("ferr_dout", 32'(dout), 32'hF0);

    // Glitch: line low for 5 cycles only.
    v0 = n_valid; f0 = n_ferr;
    rxd = 1'b0;
    wait_n(3);
    check_eq("glitch_busy_hi", 32'(busy), 32'd1);
    wait_n(2);
    rxd = 1'b1;
    wait_n(20);
    check_eq("glitch_busy_lo", 32'(busy), 32'd0);
    check_eq("glitch_nvalid", 32'(n_valid - v0), 32'd0);
    check_eq("glitch_nferr", 32'(n_ferr - f0), 32'd0);
    check_eq("glitch_dout", 32'(dout), 32'hF0);

    // Reset during data bit 4 of 0x55, then a full frame 0x12.
    v0 = n_valid; f0 = n_ferr;
    begin
      logic [7:0] b55;
      b55 = 8'h55;
      rxd = 1'b0;
      wait_n(DIV);
      for (int i = 0; i < 4; i++) begin
        rxd = b55[i];
        wait_n(DIV);
      end
      rxd = b55[4];
      wait_n(DIV / 2);
    end
    check_eq("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    rxd = 1'b1;
    wait_n(2);
    check_eq("abort_dout", 32'(dout), 32'h00);
    check_eq("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_n(30);
    check_eq("abort_idle", 32'(busy), 32'd0);
    check_eq("abort_nvalid", 32'(n_valid - v0), 32'd0);
    check_eq("abort_nferr", 32'(n_ferr - f0), 32'd0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    wait_n(20);
    check_eq("post_nvalid", 32'(n_valid - v0), 32'd1);
    check_eq("post_dout", 32'(dout), 32'h12);

    // Timing of the valid pulse for 0xFF.
    // rxd changes 2 cycles before rxd_s does, and valid rises 153 cycles after t0,
    // so valid is first seen 155 clock cycles after rxd goes low.
    v0 = n_valid;
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    wait_n(20);
    check_eq("ff_nvalid", 32'(n_valid - v0), 32'd1);
    check_eq("ff_valid_time", 32'((t_valid - t_start) / CLK_PERIOD), 32'd155);

    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate; bit period DIV = CLK_HZ/BAUD (integer truncation); DIV >= 4 required.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port rxd  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-006 SHALL have port dout  output  8  last correctly received byte, held until next good frame.
REQ-007 SHALL have port valid  output  1  one-cycle pulse when dout updates.
REQ-008 SHALL have port ferr  output  1  one-cycle pulse on framing error (stop bit low).
REQ-009 SHALL have port busy  output  1  high while a frame is being received (any state except IDLE).
REQ-010 SHALL have port hex_hi  output  4  dout[7:4], direct nibble feed for the downstream seven-segment decoder.
REQ-011 SHALL have port hex_lo  output  4  dout[3:0], direct nibble feed for the downstream seven-segment decoder.

Function
REQ-012 SHALL pass rxd through a two-flop synchronizer (rxd_s); all decisions use rxd_s only; a third flop holds rxd_s of the previous cycle for edge detection.
REQ-013 SHALL implement states IDLE, START, DATA, STOP; no other reachable states.
REQ-014 IDLE: on falling edge of rxd_s (previous 1, current 0), clear bit counter, load baud counter, go to START; define t0 as that cycle.
REQ-015 START: at t0 + DIV/2 (integer) sample rxd_s; if 0 go to DATA; if 1 (glitch) return to IDLE, no valid, no ferr.
REQ-016 DATA: sample data bit k (k = 0..7) at t0 + DIV/2 + (k+1)*DIV, shift into shift register LSB first; after bit 7 go to STOP.
REQ-017 STOP: sample at t0 + DIV/2 + 9*DIV; if 1: dout <= shift register, valid = 1 in the next cycle; if 0: ferr = 1 in the next cycle, dout unchanged; either way return to IDLE.
REQ-018 valid and ferr SHALL never be high in the same cycle and each SHALL be exactly one cycle wide.
REQ-019 After return to IDLE, a new frame SHALL only start on a fresh falling edge; a line held low (break) after a framing error SHALL not retrigger reception.
REQ-020 Falling edges on rxd_s while in START, DATA or STOP SHALL be ignored (no resynchronization mid-frame).
REQ-021 Baud counter width SHALL be ceil(log2(DIV)) bits minimum; no wrap-around error for DIV up to 2^16.
REQ-022 hex_hi/hex_lo SHALL be combinational slices of dout, changing in the same cycle as dout.

Reset
REQ-023 While rst is high: state = IDLE, dout = 0x00, valid = 0, ferr = 0, busy = 0, hex_hi = hex_lo = 0, synchronizer flops = 1 (idle line), counters = 0.
REQ-024 rst asserted mid-frame SHALL abort the frame immediately; no valid or ferr pulse for the aborted frame; after release, reception starts only on a new falling edge.

Verification (bench parameters CLK_HZ = 16, BAUD = 1, DIV = 16)
REQ-025 Send 0xA5 with stop 1 -> exactly one valid pulse, dout = 0xA5, hex_hi = 0xA, hex_lo = 0x5, ferr never high, busy low after pulse.
REQ-026 Send 0x3C then 0xF0 back-to-back (next start bit directly after stop bit) -> two valid pulses, dout = 0x3C then 0xF0, no frame lost.
REQ-027 Send 0x81 with stop bit 0, then hold line low 40 cycles, then high -> one ferr pulse, dout keeps previous value, no valid, busy stays low during the hold.
REQ-028 Drive rxd low for 5 cycles then high (glitch) -> state returns to IDLE, no valid, no ferr, dout unchanged.
REQ-029 Assert rst during data bit 4 of 0x55 frame, release, then send 0x12 -> no pulse for 0x55, dout = 0x00 after reset, then valid with dout = 0x12.
REQ-030 Check valid pulse timing for 0xFF: valid high exactly at cycle t0 + 8 + 9*16 + 1 = t0 + 153 relative to first low rxd_s cycle.
